execute_pipe_stage: RTL
=======================

// Module: execute_pipe_stage
// PURPOSE
// - EX->MEM pipeline register, next generation: parametrised widths, ready/valid handshake, 2-entry skid, synchronous flush.
// - Carries ALU result, store data, rd, packed control and PC targets from execute to memory stage.
// - Back-pressure from MEM never drops or duplicates an instruction.
// - Invalid slots never assert memory or register-file side effects.
// PARAMETERS
// - DATA_WIDTH    32  ALU result / store-data width
// - ADDRESS_BITS  20  width of each PC target
// - RD_BITS       5   destination register index width
// PORTS
// - clock          in   1               single clock, rising edge
// - reset          in   1               synchronous, active-high
// - flush          in   1               kill all held and incoming entries (branch redirect)
// - in_valid       in   1               EX presents an instruction
// - in_ready       out  1               stage accepts this cycle
// - ALU_result     in   DATA_WIDTH      EX result
// - rs2_data       in   DATA_WIDTH      store data
// - rd             in   RD_BITS         destination register
// - ctrl           in   7               {zero,branch,memRead,memWrite,regWrite,next_PC_sel[1:0]}
// - targets        in   3*ADDRESS_BITS  {JAL_target,JALR_target,branch_target}
// - out_valid      out  1               MEM-side entry valid
// - out_ready      in   1               MEM consumes this cycle
// - reg_ALU_result out  DATA_WIDTH      registered fields of the head entry
// - reg_rs2_data   out  DATA_WIDTH
// - reg_rd         out  RD_BITS
// - reg_ctrl       out  7               memRead/memWrite/regWrite bits forced 0 when out_valid=0
// - reg_targets    out  3*ADDRESS_BITS
// BEHAVIOUR
// - Reset: out_valid=0, in_ready=1, all reg_* outputs 0, state EMPTY; counters 0.
// - Accept = in_valid & in_ready; consume = out_valid & out_ready.
// - Head slot drives reg_*; skid slot holds one extra entry.
// - in_ready is a register output; it is 0 only in state FULL.
// - States and transitions (flush=0):
//   - EMPTY: accept -> HEAD; else stay.
//   - HEAD: accept & consume -> HEAD with new data;
//     accept & !consume -> FULL (new data to skid);
//     !accept & consume -> EMPTY.
//   - FULL: consume -> HEAD (skid moves to head, order kept); in_ready=0, so no accept.
// - Latency: accepted entry appears at out_valid the next cycle when head is empty or being consumed.
// - Entry order is strictly FIFO; fields of one instruction never mix.
// - Data outputs hold their value while !consume.
// - flush=1: next state EMPTY, out_valid=0, in_ready=1.
//   - Flush beats a same-cycle accept; that instruction is discarded.
//   - reg_* data may keep stale values, but the gated ctrl bits read 0.
// - Reset asserted mid-operation behaves as flush and also zeroes all data outputs; reset beats flush.
// - No arithmetic on payload; widths pass through unchanged.
// CONFIGURATION
// - EXEC_PIPE_PERF_EN defined: adds two output ports.
//   - stall_cycles [31:0]: +1 each cycle with out_valid & !out_ready.
//   - flush_count [31:0]: +1 each cycle with flush=1 and at least one valid entry held.
//   - Both counters saturate at 32'hFFFFFFFF and are cleared by reset.
// - EXEC_PIPE_PERF_EN undefined: ports and counters absent; handshake behaviour identical.
// TESTING
// - Reset, then in_valid=1 with ALU_result=32'h1234, out_ready=1 -> next cycle out_valid=1, reg_ALU_result=32'h1234, in_ready=1.
// - out_ready=0; push A=1 then B=2 -> state FULL, in_ready=0, reg_ALU_result=1; out_ready=1 -> outputs 1 then 2, in_ready back to 1, no loss.
// - State FULL, then flush=1 with in_valid=1 -> next cycle out_valid=0, reg_ctrl memWrite/regWrite=0, in_ready=1; the flushed input never appears.
// - Continuous in_valid/out_ready=1 for 100 cycles with incrementing data -> 1 result/cycle, in-order, in_ready never drops.
// - Reset asserted while FULL -> next cycle out_valid=0 and all reg_* =0; first post-reset accept is delivered correctly.
// - EXEC_PIPE_PERF_EN: 5 stalled cycles then 1 flush with a valid entry -> stall_cycles=5, flush_count=1; force near-max -> saturates, no wrap.

Source files
------------

// File: rtl/execute_pipe_stage.sv
// execute_pipe_stage: EX->MEM pipeline register with a ready/valid handshake,
// a two-entry skid (head + skid slot) and a synchronous flush.
// Optional feature macro: EXEC_PIPE_PERF_EN adds stall_cycles / flush_count
// performance counters; without it the handshake behaviour is identical.
module execute_pipe_stage #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int RD_BITS      = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     ALU_result,
    input  logic [DATA_WIDTH-1:0]     rs2_data,
    input  logic [RD_BITS-1:0]        rd,
    input  logic [6:0]                ctrl,
    input  logic [3*ADDRESS_BITS-1:0] targets,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     reg_ALU_result,
    output logic [DATA_WIDTH-1:0]     reg_rs2_data,
    output logic [RD_BITS-1:0]        reg_rd,
    output logic [6:0]                reg_ctrl,
    output logic [3*ADDRESS_BITS-1:0] reg_targets
`ifdef EXEC_PIPE_PERF_EN
    ,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               flush_count
`endif
);

    localparam int PAYLOAD_W = 2*DATA_WIDTH + RD_BITS + 7 + 3*ADDRESS_BITS;

    // ctrl layout: {zero, branch, memRead, memWrite, regWrite, next_PC_sel[1:0]}
    localparam logic [6:0] SIDE_EFFECT_MASK = 7'b0011100;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HEAD  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   in_ready_q;
    logic [PAYLOAD_W-1:0]   in_payload;
    logic [PAYLOAD_W-1:0]   head_q;
    logic [PAYLOAD_W-1:0]   skid_q;
    logic [6:0]             head_ctrl;
    logic                   accept;
    logic                   consume;
    logic                   load_head_from_in;
    logic                   load_head_from_skid;
    logic                   load_skid;

    assign in_payload = {ALU_result, rs2_data, rd, ctrl, targets};
    assign out_valid  = (state_q != ST_EMPTY);
    assign in_ready   = in_ready_q;
    assign accept     = in_valid & in_ready_q;
    assign consume    = out_valid & out_ready;

    // Next-state and slot-load decisions for the skid FIFO.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d             = state_q;
        load_head_from_in   = 1'b0;
        load_head_from_skid = 1'b0;
        load_skid           = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d           = ST_HEAD;
                    load_head_from_in = 1'b1;
                end
            end
            ST_HEAD: begin
                if (accept && consume) begin
                    load_head_from_in = 1'b1;
                end else if (accept) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain path exists.
                if (consume) begin
                    state_d             = ST_HEAD;
                    load_head_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // A redirect kills both slots and any same-cycle incoming instruction.
        if (flush) begin
            state_d             = ST_EMPTY;
            load_head_from_in   = 1'b0;
            load_head_from_skid = 1'b0;
            load_skid           = 1'b0;
        end
    end

    // State register and registered in_ready (low only when the next state is FULL).
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    // Head slot: drives the reg_* outputs, zeroed by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
        end else if (load_head_from_in) begin
            head_q <= in_payload;
        end else if (load_head_from_skid) begin
            head_q <= skid_q;
        end
    end

    // Skid slot: holds the one extra entry accepted while the head is stalled.
    always_ff @(posedge clock) begin
        // NOTE: the skid slot has no reset; it is only ever read after it has been written.
        if (load_skid) begin
            skid_q <= in_payload;
        end
    end

    assign {reg_ALU_result, reg_rs2_data, reg_rd, head_ctrl, reg_targets} = head_q;

    // Memory and register-file side-effect bits never leave an empty stage.
    assign reg_ctrl = out_valid ? head_ctrl : (head_ctrl & ~SIDE_EFFECT_MASK);

`ifdef EXEC_PIPE_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Saturating counters: MEM back-pressure cycles and flushes that killed live work.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (flush && out_valid && (flush_q != 32'hFFFF_FFFF)) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule
